// File: rtl/beta_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : beta_fetch_unit_if
// Brief    : Instruction-memory and decode-side bundle for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface beta_fetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  imem_req_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic                  imem_gnt_i;
    logic                  imem_rvalid_i;
    logic [DATA_WIDTH-1:0] imem_rdata_i;
    logic                  imem_err_i;
    logic                  if_redirect_i;
    logic [ADDR_WIDTH-1:0] if_redirect_addr_i;
    logic                  if_instr_valid_o;
    logic                  if_instr_ready_i;
    logic [DATA_WIDTH-1:0] if_instr_o;
    logic [ADDR_WIDTH-1:0] if_pc_o;
    logic                  if_err_o;
    logic                  if_misaligned_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
        input  if_redirect_i, if_redirect_addr_i, if_instr_ready_i,
        output if_instr_valid_o, if_instr_o, if_pc_o, if_err_o, if_misaligned_o
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
        output if_redirect_i, if_redirect_addr_i, if_instr_ready_i,
        input  if_instr_valid_o, if_instr_o, if_pc_o, if_err_o, if_misaligned_o
    );
endinterface
`default_nettype wire

// File: rtl/beta_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : beta_fetch_unit
// Brief    : Instruction fetch with in-order prefetch FIFO and redirect flush.
//            BETA_IF_MISALIGN_EXC_EN: misaligned redirect halts and flags.
// Revision : 1.0 - initial release
// ============================================================================
module beta_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    beta_fetch_unit_if.master bus
);
    localparam int         c_ptr_w    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int         c_cnt_w    = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [0:0] c_st_run   = 1'b0;
    localparam logic [0:0] c_st_drain = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic                  r_req_en;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_target_pc;
    logic [ADDR_WIDTH-1:0] r_resp_pc;
    logic [c_cnt_w-1:0]    r_outstanding;
    logic [c_cnt_w-1:0]    r_discard;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [DATA_WIDTH-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic                  r_fifo_err   [FIFO_DEPTH];

    logic                  w_req;
    logic                  w_gnt;
    logic                  w_redirect;
    logic                  w_drop;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_halt;
    logic                  w_credit_ok;
    logic [c_cnt_w-1:0]    w_inflight;
    logic [c_cnt_w-1:0]    w_out_next;
    logic [ADDR_WIDTH-1:0] w_target;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

`ifdef BETA_IF_MISALIGN_EXC_EN
    logic r_misaligned;
    logic w_target_mis;

    assign w_target     = bus.if_redirect_addr_i;
    assign w_target_mis = |bus.if_redirect_addr_i[1:0];
    assign w_halt       = r_misaligned;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_misaligned <= 1'b0;
        end else if (w_redirect) begin
            r_misaligned <= w_target_mis;
        end
    end
`else
    assign w_target = bus.if_redirect_addr_i & ~ADDR_WIDTH'(3);
    assign w_halt   = 1'b0;
`endif

    assign w_redirect  = bus.if_redirect_i;
    assign w_gnt       = w_req & bus.imem_gnt_i;
    assign w_inflight  = r_outstanding + r_count;
    assign w_credit_ok = w_inflight < c_cnt_w'(FIFO_DEPTH);
    assign w_drop      = bus.imem_rvalid_i & (r_discard != '0);
    assign w_push      = bus.imem_rvalid_i & (r_discard == '0) & ~w_redirect;
    assign w_pop       = (r_count != '0) & bus.if_instr_ready_i & ~w_redirect;
    // Everything still in flight after this edge, including a same-cycle grant.
    assign w_out_next  = r_outstanding + c_cnt_w'(w_gnt) - c_cnt_w'(bus.imem_rvalid_i);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_run:   if (w_redirect && w_req && !bus.imem_gnt_i) w_state_next = c_st_drain;
            c_st_drain: if (bus.imem_gnt_i) w_state_next = c_st_run;
            default:    w_state_next = c_st_run;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_req = 1'b0;
        if (r_req_en) begin
            w_req = (r_state == c_st_drain) ? 1'b1 : (w_credit_ok && !w_halt);
        end
        bus.imem_req_o       = w_req;
        bus.imem_addr_o      = r_fetch_pc;
        bus.if_instr_valid_o = (r_count != '0);
        bus.if_instr_o       = r_fifo_instr[r_rd_ptr];
        bus.if_pc_o          = r_fifo_pc[r_rd_ptr];
        bus.if_err_o         = r_fifo_err[r_rd_ptr];
        bus.if_misaligned_o  = 1'b0;
`ifdef BETA_IF_MISALIGN_EXC_EN
        if (r_misaligned) begin
            bus.if_instr_valid_o = 1'b1;
            bus.if_instr_o       = '0;
            bus.if_pc_o          = r_target_pc;
            bus.if_err_o         = 1'b0;
            bus.if_misaligned_o  = 1'b1;
        end
`endif
    end

    // ---------------- Fetch address and transaction bookkeeping ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_en      <= 1'b0;
            r_fetch_pc    <= BOOT_ADDR;
            r_target_pc   <= BOOT_ADDR;
            r_resp_pc     <= BOOT_ADDR;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_req_en      <= 1'b1;
            r_outstanding <= w_out_next;
            if (w_redirect) begin
                r_target_pc <= w_target;
                r_resp_pc   <= w_target;
                r_discard   <= w_out_next;
                // A pending ungranted beat keeps its address until accepted.
                if (!(w_req && !bus.imem_gnt_i)) begin
                    r_fetch_pc <= w_target;
                end
            end else begin
                r_discard <= r_discard - c_cnt_w'(w_drop)
                           + c_cnt_w'((r_state == c_st_drain) && w_gnt);
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + ADDR_WIDTH'(4);
                end
                if (w_gnt) begin
                    r_fetch_pc <= (r_state == c_st_drain) ? r_target_pc
                                                          : r_fetch_pc + ADDR_WIDTH'(4);
                end
            end
        end
    end

    // ---------------- Prefetch FIFO ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= BOOT_ADDR;
                r_fifo_err[i]   <= 1'b0;
            end
        end else if (w_redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= bus.imem_err_i ? '0 : bus.imem_rdata_i;
                r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
                r_fifo_err[r_wr_ptr]   <= bus.imem_err_i;
                r_wr_ptr               <= ptr_inc(r_wr_ptr);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_beta_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_fetch_unit
// Brief    : Directed scoreboard bench for beta_fetch_unit with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beta_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    beta_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    beta_fetch_unit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .BOOT_ADDR(32'h0000_0000), .FIFO_DEPTH(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mem_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } exp_t;

    mem_t        mq[$];
    exp_t        exp_q[$];
    int          cyc       = 0;
    int          mem_lat   = 1;
    int          grant_cnt = 0;
    logic        err_en    = 1'b0;
    logic [31:0] err_addr  = 32'h0;
    int          n_checks  = 0;
    int          n_errors  = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // In-order memory: responds mem_lat cycles after each grant.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
        end else if (bus.imem_req_o && bus.imem_gnt_i) begin
            mq.push_back('{addr: bus.imem_addr_o, due: cyc + mem_lat - 1});
            grant_cnt++;
        end
        #1;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_data(mq[0].addr);
            bus.imem_err_i    = err_en && (mq[0].addr == err_addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = 32'h0;
            bus.imem_err_i    = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc    = start + 32'(4 * i);
            e.err   = err_en && (e.pc == err_addr);
            e.instr = e.err ? 32'h0 : mem_data(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.if_redirect_i      = 1'b1;
        bus.if_redirect_addr_i = target;
        exp_q.delete();
        @(negedge clk);
        bus.if_redirect_i = 1'b0;
    endtask

    // Accept n entries from decode side, comparing each against the scoreboard.
    task automatic take(input int n);
        for (int i = 0; i < n; i++) begin
            int   t;
            exp_t e;
            t = 0;
            bus.if_instr_ready_i = 1'b1;
            while (!bus.if_instr_valid_o && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("take_valid", 32'(bus.if_instr_valid_o), 32'd1);
            if (!bus.if_instr_valid_o) break;
            e = exp_q.pop_front();
            check("take_pc",    bus.if_pc_o,           e.pc);
            check("take_instr", bus.if_instr_o,        e.instr);
            check("take_err",   32'(bus.if_err_o),     32'(e.err));
            check("take_mis",   32'(bus.if_misaligned_o), 32'd0);
            @(negedge clk);
        end
        bus.if_instr_ready_i = 1'b0;
    endtask

    initial begin
        bus.imem_gnt_i         = 1'b1;
        bus.imem_rvalid_i      = 1'b0;
        bus.imem_rdata_i       = 32'h0;
        bus.imem_err_i         = 1'b0;
        bus.if_redirect_i      = 1'b0;
        bus.if_redirect_addr_i = 32'h0;
        bus.if_instr_ready_i   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req",   32'(bus.imem_req_o),       32'd0);
        check("rst_addr",  bus.imem_addr_o,           32'h0);
        check("rst_valid", 32'(bus.if_instr_valid_o), 32'd0);
        check("rst_instr", bus.if_instr_o,            32'h0);
        check("rst_pc",    bus.if_pc_o,               32'h0);
        check("rst_err",   32'(bus.if_err_o),         32'd0);
        check("rst_mis",   32'(bus.if_misaligned_o),  32'd0);
        rst = 1'b0;
        check("rel_req0",  32'(bus.imem_req_o),       32'd0);

        // Startup latency and credit limit with decode stalled
        @(negedge clk);
        check("first_req",  32'(bus.imem_req_o),       32'd1);
        check("first_addr", bus.imem_addr_o,           32'h0);
        @(negedge clk);
        check("second_addr", bus.imem_addr_o,          32'h4);
        check("valid_lat2",  32'(bus.if_instr_valid_o), 32'd0);
        @(negedge clk);
        check("valid_lat3",  32'(bus.if_instr_valid_o), 32'd1);
        check("valid_pc0",   bus.if_pc_o,              32'h0);
        repeat (3) @(negedge clk);
        check("full_req",   32'(bus.imem_req_o), 32'd0);
        check("full_addr",  bus.imem_addr_o,     32'h8);
        check("full_grants", 32'(grant_cnt),     32'd2);
        exp_seq(32'h0, 3);
        take(3);

        // Flush, then redirect with two responses in flight
        repeat (4) @(negedge clk);
        redirect(32'h80);
        bus.imem_gnt_i = 1'b0;
        mem_lat = 3;
        check("flush_valid", 32'(bus.if_instr_valid_o), 32'd0);
        repeat (3) @(negedge clk);
        check("hold_req",  32'(bus.imem_req_o), 32'd1);
        check("hold_addr", bus.imem_addr_o,     32'h80);
        bus.imem_gnt_i = 1'b1;
        repeat (2) @(negedge clk);
        check("two_out_req", 32'(bus.imem_req_o), 32'd0);
        redirect(32'h100);
        exp_seq(32'h100, 2);
        take(2);

        // Redirect while a request waits for grant
        mem_lat = 1;
        redirect(32'h180);
        bus.imem_gnt_i = 1'b0;
        repeat (5) @(negedge clk);
        check("wait_req",  32'(bus.imem_req_o), 32'd1);
        check("wait_addr", bus.imem_addr_o,     32'h180);
        redirect(32'h200);
        for (int i = 0; i < 3; i++) begin
            check("drain_req",  32'(bus.imem_req_o), 32'd1);
            check("drain_addr", bus.imem_addr_o,     32'h180);
            @(negedge clk);
        end
        bus.imem_gnt_i = 1'b1;
        @(negedge clk);
        check("drain_next_addr", bus.imem_addr_o, 32'h200);
        exp_seq(32'h200, 2);
        take(2);

        // Bus error on pc 0x8
        err_en   = 1'b1;
        err_addr = 32'h8;
        redirect(32'h0);
        exp_seq(32'h0, 4);
        take(4);
        err_en = 1'b0;

        // Fetch PC wrap at the top of the address space
        redirect(32'hFFFF_FFF8);
        exp_seq(32'hFFFF_FFF8, 3);
        take(3);

        // Redirect coinciding with a pop, immediately followed by a second redirect
        repeat (4) @(negedge clk);
        mem_lat = 3;
        check("b2b_pre_valid", 32'(bus.if_instr_valid_o), 32'd1);
        bus.if_instr_ready_i   = 1'b1;
        bus.if_redirect_i      = 1'b1;
        bus.if_redirect_addr_i = 32'h400;
        @(negedge clk);
        bus.if_instr_ready_i   = 1'b0;
        bus.if_redirect_addr_i = 32'h500;
        @(negedge clk);
        bus.if_redirect_i = 1'b0;
        exp_q.delete();
        exp_seq(32'h500, 3);
        take(3);

        // Misaligned redirect target
        mem_lat = 1;
        redirect(32'h102);
`ifdef BETA_IF_MISALIGN_EXC_EN
        repeat (3) @(negedge clk);
        bus.if_instr_ready_i = 1'b1;
        @(negedge clk);
        bus.if_instr_ready_i = 1'b0;
        check("mis_flag",  32'(bus.if_misaligned_o),  32'd1);
        check("mis_valid", 32'(bus.if_instr_valid_o), 32'd1);
        check("mis_pc",    bus.if_pc_o,               32'h102);
        check("mis_instr", bus.if_instr_o,            32'h0);
        check("mis_req",   32'(bus.imem_req_o),       32'd0);
        redirect(32'h300);
        check("mis_clear", 32'(bus.if_misaligned_o), 32'd0);
        exp_seq(32'h300, 2);
        take(2);
`else
        check("mis_tied", 32'(bus.if_misaligned_o), 32'd0);
        exp_seq(32'h100, 2);
        take(2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
